// File: rtl/rce_pkg.sv
// Shared constants for the quasi-cyclic encoder: frame geometry, the eight
// base generator rows and the 256-bit rotate-left helper.
package rce_pkg;
    localparam int K      = 1024;
    localparam int M      = 256;
    localparam int LANES  = 8;
    localparam int OCTETS = K / LANES;
    localparam int CW     = $clog2(K);
    localparam int LB     = $clog2(LANES);
    localparam int OW     = $clog2(OCTETS);

    // Row l has a one wherever (j + 37*l) mod 16 lands on 0, 3 or 7.
    function automatic logic [M-1:0] base_row(input int l);
        logic [M-1:0] r;
        int t;
        r = '0;
        for (int j = 0; j < M; j++) begin
            t = (j + 37 * l) % 16;
            r[j] = (t == 0) || (t == 3) || (t == 7);
        end
        return r;
    endfunction

    localparam logic [M-1:0] BASE [LANES] = '{
        base_row(0), base_row(1), base_row(2), base_row(3),
        base_row(4), base_row(5), base_row(6), base_row(7)
    };

    function automatic logic [M-1:0] rotl(input logic [M-1:0] v, input logic [OW-1:0] amt);
        logic [2*M-1:0] t;
        t = {v, v} << amt;
        return t[2*M-1:M];
    endfunction
endpackage

// File: rtl/rce_layer.sv
// One generator lane: the base row rotated by the octet index, gated by the
// message bit that owns this lane.
module rce_layer
    import rce_pkg::*;
(
    input  logic          data_bit,
    input  logic [M-1:0]  base,
    input  logic [OW-1:0] amt,
    output logic [M-1:0]  row
);
    always_comb begin
        row = data_bit ? rotl(base, amt) : '0;
    end
endmodule

// File: rtl/parallel_rce_lm_encoder.sv
// Serial-in systematic encoder: echoes message bits on y, folds each completed
// octet into a parity accumulator and streams the 256 parity bits MSB first.
module parallel_rce_lm_encoder
    import rce_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic msg,
    input  logic datavalid,
    output logic y,
    output logic y_valid,
    output logic p,
    output logic p_valid
);
    logic [CW-1:0]    bit_cnt;
    logic [LANES-1:0] octet;
    logic             oct_done;
    logic [OW-1:0]    oct_idx;
    logic [M-1:0]     lane_row [LANES];
    logic [M-1:0]     pr_reg [LANES];
    logic             stage_valid;
    logic             stage_first;
    logic             stage_last;
    logic [M-1:0]     pr;
    logic [M-1:0]     q12;
    logic             q_last;
    logic [M-1:0]     shadow;
    logic [7:0]       par_cnt;

    // The earliest bit of an octet ends up in octet[0], i.e. lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            y        <= 1'b0;
            y_valid  <= 1'b0;
            bit_cnt  <= '0;
            octet    <= '0;
            oct_done <= 1'b0;
            oct_idx  <= '0;
        end else begin
            y_valid  <= datavalid;
            oct_done <= 1'b0;
            if (datavalid) begin
                y       <= msg;
                bit_cnt <= bit_cnt + 1'b1;
                octet   <= {msg, octet[LANES-1:1]};
                if (&bit_cnt[LB-1:0]) begin
                    oct_done <= 1'b1;
                    oct_idx  <= bit_cnt[CW-1:LB];
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        rce_layer u_layer (
            .data_bit (octet[l]),
            .base     (BASE[l]),
            .amt      (oct_idx),
            .row      (lane_row[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_first <= 1'b0;
            stage_last  <= 1'b0;
            for (int l = 0; l < LANES; l++) pr_reg[l] <= '0;
        end else begin
            stage_valid <= oct_done;
            if (oct_done) begin
                for (int l = 0; l < LANES; l++) pr_reg[l] <= lane_row[l];
                stage_first <= (oct_idx == '0);
                stage_last  <= &oct_idx;
            end
        end
    end

    always_comb begin
        pr = '0;
        for (int l = 0; l < LANES; l++) pr = pr ^ pr_reg[l];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q12    <= '0;
            q_last <= 1'b0;
        end else begin
            q_last <= stage_valid & stage_last;
            if (stage_valid) q12 <= (stage_first ? '0 : q12) ^ pr;
        end
    end

    // The first parity bit leaves on the load edge itself, so the shadow keeps
    // only the remaining 255 bits; a fresh load always restarts the stream.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            par_cnt <= '0;
            p       <= 1'b0;
            p_valid <= 1'b0;
        end else if (q_last) begin
            shadow  <= {q12[M-2:0], 1'b0};
            p       <= q12[M-1];
            p_valid <= 1'b1;
            par_cnt <= 8'(M - 1);
        end else if (par_cnt != '0) begin
            shadow  <= {shadow[M-2:0], 1'b0};
            p       <= shadow[M-1];
            par_cnt <= par_cnt - 1'b1;
        end else begin
            p_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_parallel_rce_lm_encoder.sv
// Self-checking bench: table of frames fed back-to-back through a scoreboard,
// then hand-written reset-mid-frame and all-ones sequences.
module tb_parallel_rce_lm_encoder;
    import rce_pkg::*;

    logic clk = 1'b0;
    logic rst, msg, datavalid;
    logic y, y_valid, p, p_valid;

    always #5 clk = ~clk;

    parallel_rce_lm_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .msg       (msg),
        .datavalid (datavalid),
        .y         (y),
        .y_valid   (y_valid),
        .p         (p),
        .p_valid   (p_valid)
    );

    typedef struct {
        logic [K-1:0] bits;
        int           gap;
        logic [M-1:0] exp_par;
    } vec_t;

    typedef struct {
        logic [M-1:0] par;
        int           end_cyc;
    } par_exp_t;

    logic         yq [$];
    par_exp_t     parq [$];
    logic [M-1:0] cap [16];
    int           ncap = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    logic         dv_prev = 1'b0;
    logic         mon_en = 1'b0;
    logic         q_chk = 1'b0;
    int           q_oct = 0;
    logic [M-1:0] q_exp;
    logic [K-1:0] q_bits;

    task automatic checkOutput(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Golden row: bit j of rotl(BASE[l], o) is base bit (j - o) mod 256.
    function automatic logic [M-1:0] modelRow(input int k);
        int l, o, b, t;
        logic [M-1:0] r;
        l = k % 8;
        o = k / 8;
        for (int j = 0; j < M; j++) begin
            b = (j - o + M) % M;
            t = (b + 37 * l) % 16;
            r[j] = (t == 0) || (t == 3) || (t == 7);
        end
        return r;
    endfunction

    function automatic logic [M-1:0] modelParity(input logic [K-1:0] u);
        logic [M-1:0] r;
        r = '0;
        for (int k = 0; k < K; k++) if (u[k]) r = r ^ modelRow(k);
        return r;
    endfunction

    function automatic logic [K-1:0] wordFrame(input logic [31:0] xr);
        logic [31:0] w [32];
        logic [31:0] cur;
        logic [K-1:0] u;
        w[0] = 32'hD9DA7BEA;
        w[1] = 32'h1A31D8AB;
        for (int i = 2; i < 32; i++) w[i] = w[i-1] * 32'd1664525 + 32'd1013904223;
        for (int k = 0; k < K; k++) begin
            cur = w[k / 32] ^ xr;
            u[k] = cur[31 - (k % 32)];
        end
        return u;
    endfunction

    task automatic applyStimulus(input logic [K-1:0] u, input int gap, input int nbits, input logic [M-1:0] exp_par);
        par_exp_t pe;
        for (int k = 0; k < nbits; k++) begin
            while (gap > 0 && int'($urandom_range(99)) < gap) begin
                datavalid = 1'b0;
                msg = 1'($urandom_range(1));
                @(posedge clk); #1;
            end
            datavalid = 1'b1;
            msg = u[k];
            yq.push_back(u[k]);
            @(posedge clk); #1;
        end
        datavalid = 1'b0;
        msg = 1'b0;
        if (nbits == K) begin
            pe.par = exp_par;
            pe.end_cyc = cyc;
            parq.push_back(pe);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((parq.size() != 0 || yq.size() != 0) && budget < 3000) begin
            @(posedge clk); #1;
            budget++;
        end
        repeat (300) @(posedge clk);
        #1;
        checkOutput("drain_queues_empty", M'(parq.size() + yq.size()), '0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        dv_prev <= datavalid & ~rst;
    end

    initial begin
        logic [M-1:0] pbuf;
        int pcount;
        logic have_exp;
        logic stage_prev;
        par_exp_t cur;
        pcount = 0;
        have_exp = 1'b0;
        stage_prev = 1'b0;
        pbuf = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checkOutput("y_valid", M'(y_valid), M'(dv_prev));
                if (y_valid) begin
                    if (yq.size() == 0) checkOutput("y_unexpected", M'(1), M'(0));
                    else checkOutput("y", M'(y), M'(yq.pop_front()));
                end
                if (p_valid) begin
                    if (pcount == 0) begin
                        if (parq.size() == 0) begin
                            have_exp = 1'b0;
                            checkOutput("p_valid_unexpected", M'(1), M'(0));
                        end else begin
                            have_exp = 1'b1;
                            cur = parq.pop_front();
                            checkOutput("parity_latency", M'(cyc - cur.end_cyc), M'(3));
                        end
                    end
                    pbuf = {pbuf[M-2:0], p};
                    pcount++;
                    if (pcount == M) begin
                        if (have_exp) checkOutput("parity", pbuf, cur.par);
                        cap[ncap % 16] = pbuf;
                        ncap++;
                        pcount = 0;
                    end
                end else if (pcount != 0) begin
                    checkOutput("p_valid_length", M'(pcount), M'(M));
                    pcount = 0;
                end
                if (q_chk && stage_prev) begin
                    for (int l = 0; l < LANES; l++)
                        if (q_bits[q_oct * 8 + l]) q_exp = q_exp ^ modelRow(q_oct * 8 + l);
                    checkOutput($sformatf("q12_octet_%0d", q_oct), dut.q12, q_exp);
                    q_oct++;
                end
            end
            stage_prev = dut.stage_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [6];
        logic [K-1:0] u;
        logic [M-1:0] lin;

        u = '0; u[0] = 1'b1;
        vecs[0] = '{bits: u, gap: 0, exp_par: modelParity(u)};
        u = '0; u[9] = 1'b1;
        vecs[1] = '{bits: u, gap: 0, exp_par: modelParity(u)};
        u = wordFrame(32'd0);
        vecs[2] = '{bits: u, gap: 0, exp_par: modelParity(u)};
        u = wordFrame(32'd1);
        vecs[3] = '{bits: u, gap: 0, exp_par: modelParity(u)};
        u = wordFrame(32'd3);
        vecs[4] = '{bits: u, gap: 0, exp_par: modelParity(u)};
        u = wordFrame(32'd0);
        vecs[5] = '{bits: u, gap: 30, exp_par: modelParity(u)};

        rst = 1'b1;
        msg = 1'b0;
        datavalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_y", M'(y), '0);
        checkOutput("reset_y_valid", M'(y_valid), '0);
        checkOutput("reset_p", M'(p), '0);
        checkOutput("reset_p_valid", M'(p_valid), '0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i].bits, vecs[i].gap, K, vecs[i].exp_par);
        drain();

        checkOutput("stream_count", M'(ncap), M'(6));
        checkOutput("single_bit_base0", cap[0], modelRow(0));
        checkOutput("rotation_u9", cap[1], modelRow(9));
        lin = '0;
        for (int w = 0; w < 32; w++) lin = lin ^ modelRow(32 * w + 31);
        checkOutput("linearity_AB", cap[2] ^ cap[3], lin);
        lin = '0;
        for (int w = 0; w < 32; w++) lin = lin ^ modelRow(32 * w + 30);
        checkOutput("linearity_BC", cap[3] ^ cap[4], lin);
        checkOutput("gaps_vs_gapless", cap[5], cap[2]);

        // A partial frame followed by reset must vanish without any parity.
        applyStimulus(vecs[2].bits, 0, 500, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("midreset_y", M'(y), '0);
        checkOutput("midreset_y_valid", M'(y_valid), '0);
        checkOutput("midreset_p", M'(p), '0);
        checkOutput("midreset_p_valid", M'(p_valid), '0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        applyStimulus(vecs[4].bits, 0, K, vecs[4].exp_par);
        drain();

        u = '1;
        q_bits = u;
        q_exp = '0;
        q_oct = 0;
        q_chk = 1'b1;
        applyStimulus(u, 0, K, modelParity(u));
        drain();
        q_chk = 1'b0;
        checkOutput("q12_octet_count", M'(q_oct), M'(OCTETS));
        checkOutput("total_streams", M'(ncap), M'(8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/parallel_rce_lm_encoder.md
Name: parallel_rce_lm_encoder

Overview:
- Serial-in, parallel-compute systematic encoder for quasi-cyclic codes.
- Takes one message bit per clock and forwards it unchanged on y (systematic stream).
- Computes 256 parity bits per 1024-bit frame using 8 parallel layer registers and a parity accumulator.
- Streams the parity serially on p while the next frame is being received. Sits between the message source and the channel mapper.

Parameters:
K, 1024, message bits per frame
M, 256, parity bits per frame
LANES, 8, parallel layers (message bits per octet)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
msg  input  1  message bit, first bit of frame = index k=0
datavalid  input  1  msg accepted on a clock edge where datavalid=1
y  output  1  systematic bit (registered copy of accepted msg)
y_valid  output  1  y carries an accepted bit
p  output  1  serial parity bit, MSB (bit M-1) first
p_valid  output  1  p carries a parity bit

Behaviour:
- Reset (rst=1 at an edge): all of the following cleared to 0.
  - Outputs y, y_valid, p, p_valid.
  - Bit counter and octet shift register.
  - pr1..pr8 and q12.
  - Parity shadow register and its 8-bit parity counter.
  - Reset mid-frame discards the partial frame; the next accepted bit is k=0.
- Generator: message bit k (0..1023) with o=k/8 and l=k%8 contributes row G_k = rotl(BASE[l], o), a 256-bit rotate-left by o.
  - BASE[l] bit j = 1 iff ((j + 37*l) mod 16) is in {0,3,7}.
  - Parity P = XOR over all k with u_k=1 of G_k.
- Systematic path: on an accepted bit, y<=msg and y_valid<=1 on the same edge (1-cycle latency). Otherwise y_valid<=0 and y holds its value.
- Bit counter 0..1023 counts accepted bits and wraps to 0 after 1023. Accepted bits shift into the octet register.
- Layer stage: on the edge after the 8th bit of an octet is accepted (cycle T+1, where T is the acceptance edge):
  - pr_l <= octet bit l ? rotl(BASE[l], o) : 0, for l=1..8 mapping to lane l-1.
  - A stage-valid flag is set for one cycle.
- pr is the combinational XOR of pr1..pr8.
- Accumulator q12, on the edge after stage-valid (T+2): q12 <= (first octet of frame ? 0 : q12) XOR pr.
- Frame end: on the edge after q12 absorbs octet 127 (T+3), the shadow register <= q12 and the parity counter <= 255.
  - p_valid=1 for 256 consecutive cycles starting that cycle.
  - p = shadow[255] first, then bits 254..0, shifting left.
- Parity streaming ignores datavalid and overlaps the next frame.
  - 256 < 1024, so a shadow load never collides with an active stream when frames are back-to-back.
  - If a new load coincides with an active stream, the load wins and the stream restarts.
- datavalid=0 pauses acceptance; pipeline stages already in flight still complete.
- Latency: last message bit accepted at edge T yields first parity bit on p at edge T+3.

Decomposition:
- Package rce_pkg:
  - K, M, LANES.
  - 256-bit BASE[0..7] constant array.
  - A rotl function.
- One sub-module, rce_layer: computes a single pr_l from (bit, BASE, rotate amount).
  - Instantiated LANES times.

Test Plan:
- Single-bit frame: u_0=1, rest 0.
  - y echoes every bit with 1-cycle latency.
  - p streams BASE[0], MSB first; p_valid high for exactly 256 cycles starting 3 cycles after bit 1023.
- Rotation: u_9=1 only (o=1, l=1) -> parity = rotl(BASE[1],1).
- Linearity: frame A = 32 words D9DA7BEA, 1A31D8AB, ..., fed MSB-first; frame B = same words XOR 1; frame C = same words XOR 3; fed back-to-back with no gaps.
  - Each parity equals the golden-model XOR of rows.
  - P_A XOR P_B equals the XOR of the rows of the toggled bit positions.
- datavalid gaps: random datavalid=0 insertions.
  - Parity is identical to the gapless run.
  - y_valid mirrors datavalid with 1-cycle latency.
- Reset mid-frame: rst=1 after 500 bits.
  - All outputs are 0 the next cycle, no parity emitted.
  - A following clean frame encodes correctly.
- All-ones frame: parity equals the XOR of all 1024 rows from the golden model.
  - q12 is checked after every octet.
